// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer for the 8-bit core: FETCH -> DECODE -> EXECUTE -> WRITEBACK,
// with run/step/halt debug control, illegal-opcode trapping and a retired-instruction counter.
module cpu_sequencer #(
    parameter int PC_WIDTH      = 8,
    parameter int NumOpCodeBits = 5,
    parameter int RetCntWidth   = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     run,
    input  logic                     step,
    input  logic                     halt_req,
    input  logic                     fault_clr,
    input  logic                     imem_ack,
    input  logic [NumOpCodeBits-1:0] opcode,
    input  logic                     dec_wr_en,
    input  logic                     dec_stat_wr_en,
    input  logic                     dec_cnt_wr_en,
    output logic                     imem_req,
    output logic                     ir_load,
    output logic                     reg_wr_en,
    output logic                     stat_wr_en,
    output logic                     pc_wr_en,
    output logic                     pc_inc,
    output logic                     busy,
    output logic                     halted,
    output logic                     fault,
    output logic [RetCntWidth-1:0]   retired_cnt,
    output logic [2:0]               state_dbg
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_FAULT     = 3'd5
    } state_t;

    // PC_WIDTH only documents the PC this block steers; the PC itself lives in the datapath.
    if (PC_WIDTH > 0) begin : g_pc_width_doc
    end

    state_t                 state, state_nxt;
    logic                   step_pending, step_pending_nxt;
    logic                   halt_pending, halt_pending_nxt;
    logic                   retire;
    logic                   opcode_reserved;

    assign opcode_reserved =
        ((opcode >= NumOpCodeBits'(10)) && (opcode <= NumOpCodeBits'(15))) ||
        (opcode >= NumOpCodeBits'(22));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            step_pending <= 1'b0;
            halt_pending <= 1'b0;
            retired_cnt  <= '0;
        end else begin
            state        <= state_nxt;
            step_pending <= step_pending_nxt;
            halt_pending <= halt_pending_nxt;
            if (retire && (retired_cnt != {RetCntWidth{1'b1}})) begin
                retired_cnt <= retired_cnt + 1'b1;
            end
        end
    end

    // A halt pulse seen mid-instruction is remembered so the instruction
    // still completes and the FSM stops at the following boundary.
    always_comb begin
        state_nxt        = state;
        step_pending_nxt = step_pending;
        halt_pending_nxt = halt_pending;
        imem_req         = 1'b0;
        ir_load          = 1'b0;
        reg_wr_en        = 1'b0;
        stat_wr_en       = 1'b0;
        pc_wr_en         = 1'b0;
        pc_inc           = 1'b0;
        retire           = 1'b0;
        case (state)
            ST_IDLE: begin
                halt_pending_nxt = 1'b0;
                if (!halt_req) begin
                    if (run) begin
                        state_nxt        = ST_FETCH;
                        step_pending_nxt = 1'b0;
                    end else if (step) begin
                        state_nxt        = ST_FETCH;
                        step_pending_nxt = 1'b1;
                    end
                end
            end
            ST_FETCH: begin
                imem_req         = 1'b1;
                halt_pending_nxt = halt_pending | halt_req;
                if (imem_ack) begin
                    ir_load   = 1'b1;
                    state_nxt = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (opcode_reserved) begin
                    state_nxt        = ST_FAULT;
                    step_pending_nxt = 1'b0;
                    halt_pending_nxt = 1'b0;
                end else begin
                    state_nxt        = ST_EXECUTE;
                    halt_pending_nxt = halt_pending | halt_req;
                end
            end
            ST_EXECUTE: begin
                halt_pending_nxt = halt_pending | halt_req;
                state_nxt        = ST_WRITEBACK;
            end
            ST_WRITEBACK: begin
                reg_wr_en        = dec_wr_en;
                stat_wr_en       = dec_stat_wr_en;
                pc_wr_en         = dec_cnt_wr_en;
                pc_inc           = ~dec_cnt_wr_en;
                retire           = 1'b1;
                halt_pending_nxt = 1'b0;
                if (halt_req || halt_pending || step_pending || !run) begin
                    state_nxt        = ST_IDLE;
                    step_pending_nxt = 1'b0;
                end else begin
                    state_nxt = ST_FETCH;
                end
            end
            ST_FAULT: begin
                step_pending_nxt = 1'b0;
                halt_pending_nxt = 1'b0;
                if (fault_clr) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt        = ST_IDLE;
                step_pending_nxt = 1'b0;
                halt_pending_nxt = 1'b0;
            end
        endcase
    end

    assign busy      = (state == ST_FETCH) || (state == ST_DECODE) ||
                       (state == ST_EXECUTE) || (state == ST_WRITEBACK);
    assign halted    = (state == ST_IDLE) || (state == ST_FAULT);
    assign fault     = (state == ST_FAULT);
    assign state_dbg = state;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: per-cycle strobe/status vectors with hand-computed expectations.
module tb_cpu_sequencer;

    localparam int OPW = 5;
    localparam int RW  = 3;

    localparam logic [4:0] OP_NOP  = 5'b00000;
    localparam logic [4:0] OP_ADD  = 5'b00001;
    localparam logic [4:0] OP_GOTO = 5'b10000;
    localparam logic [4:0] OP_BAD  = 5'b01011;

    // {busy, halted, fault}
    localparam logic [2:0] F_IDLE  = 3'b010;
    localparam logic [2:0] F_BUSY  = 3'b100;
    localparam logic [2:0] F_FAULT = 3'b011;

    logic           clk;
    logic           rst_n;
    logic           run;
    logic           step;
    logic           halt_req;
    logic           fault_clr;
    logic           imem_ack;
    logic [OPW-1:0] opcode;
    logic           dec_wr_en;
    logic           dec_stat_wr_en;
    logic           dec_cnt_wr_en;
    logic           imem_req;
    logic           ir_load;
    logic           reg_wr_en;
    logic           stat_wr_en;
    logic           pc_wr_en;
    logic           pc_inc;
    logic           busy;
    logic           halted;
    logic           fault;
    logic [RW-1:0]  retired_cnt;
    logic [2:0]     state_dbg;

    int checks;
    int failures;

    cpu_sequencer #(
        .PC_WIDTH      (8),
        .NumOpCodeBits (OPW),
        .RetCntWidth   (RW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .run            (run),
        .step           (step),
        .halt_req       (halt_req),
        .fault_clr      (fault_clr),
        .imem_ack       (imem_ack),
        .opcode         (opcode),
        .dec_wr_en      (dec_wr_en),
        .dec_stat_wr_en (dec_stat_wr_en),
        .dec_cnt_wr_en  (dec_cnt_wr_en),
        .imem_req       (imem_req),
        .ir_load        (ir_load),
        .reg_wr_en      (reg_wr_en),
        .stat_wr_en     (stat_wr_en),
        .pc_wr_en       (pc_wr_en),
        .pc_inc         (pc_inc),
        .busy           (busy),
        .halted         (halted),
        .fault          (fault),
        .retired_cnt    (retired_cnt),
        .state_dbg      (state_dbg)
    );

    // {imem_req, ir_load, reg_wr_en, stat_wr_en, pc_wr_en, pc_inc}
    logic [5:0] strobes;
    logic [2:0] flags;
    assign strobes = {imem_req, ir_load, reg_wr_en, stat_wr_en, pc_wr_en, pc_inc};
    assign flags   = {busy, halted, fault};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "time limit");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Entered 2ns after a rising edge: drive inputs, check settled outputs, advance one cycle.
    task automatic run_cycle(input string tag, input logic ack, input logic [4:0] op,
                             input logic dwr, input logic dst, input logic dcnt,
                             input logic [5:0] exp_strb, input logic [2:0] exp_flags);
        imem_ack       = ack;
        opcode         = op;
        dec_wr_en      = dwr;
        dec_stat_wr_en = dst;
        dec_cnt_wr_en  = dcnt;
        #2;
        check_eq({tag, "_strb"}, 32'(strobes), 32'(exp_strb));
        check_eq({tag, "_flags"}, 32'(flags), 32'(exp_flags));
        @(posedge clk);
        #2;
    endtask

    // One instruction with a zero-wait-state memory, starting in FETCH.
    task automatic run_instr(input string tag, input logic [4:0] op, input logic dwr,
                             input logic dst, input logic dcnt, input logic drop_run);
        run_cycle({tag, "_f"}, 1'b1, op, dwr, dst, dcnt, 6'b110000, F_BUSY);
        run_cycle({tag, "_d"}, 1'b0, op, dwr, dst, dcnt, 6'b000000, F_BUSY);
        run_cycle({tag, "_e"}, 1'b0, op, dwr, dst, dcnt, 6'b000000, F_BUSY);
        if (drop_run) run = 1'b0;
        run_cycle({tag, "_w"}, 1'b0, op, dwr, dst, dcnt, {2'b00, dwr, dst, dcnt, ~dcnt}, F_BUSY);
    endtask

    task automatic do_reset(input string tag);
        rst_n          = 1'b0;
        run            = 1'b0;
        step           = 1'b0;
        halt_req       = 1'b0;
        fault_clr      = 1'b0;
        imem_ack       = 1'b0;
        opcode         = '0;
        dec_wr_en      = 1'b0;
        dec_stat_wr_en = 1'b0;
        dec_cnt_wr_en  = 1'b0;
        @(posedge clk);
        #2;
        check_eq({tag, "_rst_strb"}, 32'(strobes), 32'(6'b000000));
        check_eq({tag, "_rst_flags"}, 32'(flags), 32'(F_IDLE));
        check_eq({tag, "_rst_cnt"}, 32'(retired_cnt), 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    logic [4:0] bnd_op [7];
    logic       bnd_ft [7];

    initial begin
        checks   = 0;
        failures = 0;
        bnd_op = '{5'b01001, 5'b01010, 5'b01111, 5'b10000, 5'b10101, 5'b10110, 5'b11111};
        bnd_ft = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

        // Free run ADD then NOP; run dropped before the NOP writeback.
        do_reset("t1");
        run = 1'b1;
        run_cycle("t1_idle", 1'b0, OP_NOP, 1'b0, 1'b0, 1'b0, 6'b000000, F_IDLE);
        run_instr("t1_add", OP_ADD, 1'b1, 1'b1, 1'b0, 1'b0);
        run_instr("t1_nop", OP_NOP, 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("t1_cnt", 32'(retired_cnt), 32'd2);
        run_cycle("t1_end", 1'b0, OP_NOP, 1'b0, 1'b0, 1'b0, 6'b000000, F_IDLE);

        // Single step of a GOTO.
        do_reset("t2");
        step = 1'b1;
        run_cycle("t2_idle", 1'b0, OP_GOTO, 1'b0, 1'b0, 1'b1, 6'b000000, F_IDLE);
        step = 1'b0;
        run_instr("t2_goto", OP_GOTO, 1'b0, 1'b0, 1'b1, 1'b0);
        run_cycle("t2_end0", 1'b0, OP_GOTO, 1'b0, 1'b0, 1'b1, 6'b000000, F_IDLE);
        run_cycle("t2_end1", 1'b0, OP_GOTO, 1'b0, 1'b0, 1'b1, 6'b000000, F_IDLE);
        check_eq("t2_cnt", 32'(retired_cnt), 32'd1);

        // Memory acks on the fourth FETCH cycle.
        do_reset("t3");
        run = 1'b1;
        run_cycle("t3_idle", 1'b0, OP_ADD, 1'b1, 1'b1, 1'b1, 6'b000000, F_IDLE);
        for (int i = 0; i < 3; i++) begin
            run_cycle("t3_wait", 1'b0, OP_ADD, 1'b1, 1'b1, 1'b1, 6'b100000, F_BUSY);
        end
        run_instr("t3_add", OP_ADD, 1'b1, 1'b0, 1'b0, 1'b1);
        run_cycle("t3_end", 1'b0, OP_ADD, 1'b1, 1'b0, 1'b0, 6'b000000, F_IDLE);
        check_eq("t3_cnt", 32'(retired_cnt), 32'd1);

        // Reserved opcode traps; run and step ignored until fault_clr.
        do_reset("t4");
        run = 1'b1;
        run_cycle("t4_idle", 1'b0, OP_BAD, 1'b1, 1'b1, 1'b1, 6'b000000, F_IDLE);
        run_cycle("t4_f", 1'b1, OP_BAD, 1'b1, 1'b1, 1'b1, 6'b110000, F_BUSY);
        run_cycle("t4_d", 1'b0, OP_BAD, 1'b1, 1'b1, 1'b1, 6'b000000, F_BUSY);
        run_cycle("t4_flt0", 1'b0, OP_BAD, 1'b1, 1'b1, 1'b1, 6'b000000, F_FAULT);
        step = 1'b1;
        run_cycle("t4_flt1", 1'b1, OP_BAD, 1'b1, 1'b1, 1'b1, 6'b000000, F_FAULT);
        step = 1'b0;
        check_eq("t4_cnt", 32'(retired_cnt), 32'd0);
        fault_clr = 1'b1;
        run_cycle("t4_clr", 1'b0, OP_BAD, 1'b1, 1'b1, 1'b1, 6'b000000, F_FAULT);
        fault_clr = 1'b0;
        run = 1'b0;
        run_cycle("t4_idle2", 1'b0, OP_BAD, 1'b1, 1'b1, 1'b1, 6'b000000, F_IDLE);

        // Reserved-range boundaries: FAULT or EXECUTE after DECODE.
        for (int i = 0; i < 7; i++) begin
            do_reset("tb");
            run = 1'b1;
            run_cycle("tb_idle", 1'b0, bnd_op[i], 1'b0, 1'b0, 1'b0, 6'b000000, F_IDLE);
            run_cycle("tb_f", 1'b1, bnd_op[i], 1'b0, 1'b0, 1'b0, 6'b110000, F_BUSY);
            run_cycle("tb_d", 1'b0, bnd_op[i], 1'b0, 1'b0, 1'b0, 6'b000000, F_BUSY);
            run_cycle($sformatf("tb_op%05b", bnd_op[i]), 1'b0, bnd_op[i], 1'b0, 1'b0, 1'b0,
                      6'b000000, bnd_ft[i] ? F_FAULT : F_BUSY);
        end

        // Halt pulse during EXECUTE: writeback completes, then IDLE.
        do_reset("t5");
        run = 1'b1;
        run_cycle("t5_idle", 1'b0, OP_ADD, 1'b1, 1'b0, 1'b0, 6'b000000, F_IDLE);
        run_cycle("t5_f", 1'b1, OP_ADD, 1'b1, 1'b0, 1'b0, 6'b110000, F_BUSY);
        run_cycle("t5_d", 1'b0, OP_ADD, 1'b1, 1'b0, 1'b0, 6'b000000, F_BUSY);
        halt_req = 1'b1;
        run_cycle("t5_e", 1'b0, OP_ADD, 1'b1, 1'b0, 1'b0, 6'b000000, F_BUSY);
        halt_req = 1'b0;
        run_cycle("t5_w", 1'b0, OP_ADD, 1'b1, 1'b0, 1'b0, 6'b001001, F_BUSY);
        run = 1'b0;
        run_cycle("t5_idle1", 1'b1, OP_ADD, 1'b1, 1'b0, 1'b0, 6'b000000, F_IDLE);
        run_cycle("t5_idle2", 1'b1, OP_ADD, 1'b1, 1'b0, 1'b0, 6'b000000, F_IDLE);
        check_eq("t5_cnt", 32'(retired_cnt), 32'd1);

        // Reset asserted during WRITEBACK of the second ADD.
        do_reset("t6");
        run = 1'b1;
        run_cycle("t6_idle", 1'b0, OP_ADD, 1'b1, 1'b1, 1'b0, 6'b000000, F_IDLE);
        run_instr("t6_add0", OP_ADD, 1'b1, 1'b1, 1'b0, 1'b0);
        run_cycle("t6_f", 1'b1, OP_ADD, 1'b1, 1'b1, 1'b0, 6'b110000, F_BUSY);
        run_cycle("t6_d", 1'b0, OP_ADD, 1'b1, 1'b1, 1'b0, 6'b000000, F_BUSY);
        run_cycle("t6_e", 1'b0, OP_ADD, 1'b1, 1'b1, 1'b0, 6'b000000, F_BUSY);
        #2;
        check_eq("t6_wb_strb", 32'(strobes), 32'(6'b001101));
        check_eq("t6_wb_cnt", 32'(retired_cnt), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("t6_async_strb", 32'(strobes), 32'(6'b000000));
        check_eq("t6_async_flags", 32'(flags), 32'(F_IDLE));
        check_eq("t6_async_cnt", 32'(retired_cnt), 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        run_cycle("t6_post", 1'b0, OP_ADD, 1'b1, 1'b1, 1'b0, 6'b000000, F_IDLE);
        run_cycle("t6_refetch", 1'b0, OP_ADD, 1'b1, 1'b1, 1'b0, 6'b100000, F_BUSY);

        // Retired counter saturates at all-ones.
        do_reset("t7");
        run = 1'b1;
        run_cycle("t7_idle", 1'b0, OP_NOP, 1'b0, 1'b0, 1'b0, 6'b000000, F_IDLE);
        for (int i = 0; i < 6; i++) begin
            run_instr("t7_nop", OP_NOP, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        check_eq("t7_cnt6", 32'(retired_cnt), 32'd6);
        for (int i = 0; i < 3; i++) begin
            run_instr("t7_nop", OP_NOP, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        check_eq("t7_sat", 32'(retired_cnt), 32'd7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Multi-cycle control FSM for the 8-bit core. Each instruction runs FETCH -> DECODE -> EXECUTE -> WRITEBACK.
- Drives program-memory requests, instruction-register load, PC increment/load and the register-file and status-register write strobes.
- Gates the decoder's combinational enables so that state changes happen in WRITEBACK only.
- Adds run/step/halt debug control, illegal-opcode trapping and a retired-instruction counter.

Parameters:
- PC_WIDTH, 8, program counter width (informational; no PC held here)
- NumOpCodeBits, 5, opcode width
- RetCntWidth, 16, retired-instruction counter width

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- run  in  1  level; 1 = free-run instructions
- step  in  1  single-cycle pulse; execute exactly one instruction from IDLE
- halt_req  in  1  level/pulse; stop at next instruction boundary
- fault_clr  in  1  pulse; leave FAULT to IDLE
- imem_ack  in  1  program memory data valid for current request
- opcode  in  NumOpCodeBits  opcode from decoder (IR-driven)
- dec_wr_en  in  1  decoder register-file write enable
- dec_stat_wr_en  in  1  decoder status write enable
- dec_cnt_wr_en  in  1  decoder PC-load request (GOTO / taken IFZ)
- imem_req  out  1  program memory read request
- ir_load  out  1  load instruction register
- reg_wr_en  out  1  gated register-file write
- stat_wr_en  out  1  gated status-register write
- pc_wr_en  out  1  load PC from decoder (absolute/offset per decoder add_offset)
- pc_inc  out  1  PC <= PC+1
- busy  out  1  1 in FETCH/DECODE/EXECUTE/WRITEBACK
- halted  out  1  1 in IDLE
- fault  out  1  1 in FAULT
- retired_cnt  out  RetCntWidth  instructions completed

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; step_pending=0; retired_cnt=0.
  - All strobes 0, busy=0, halted=1, fault=0.
- All outputs are decoded from registered state only. None are combinational from run/step/imem_ack, except ir_load (see FETCH).
- IDLE:
  - run=1 -> FETCH.
  - Else step=1 -> FETCH with step_pending=1.
  - halt_req has priority over run/step in IDLE: stay in IDLE.
- FETCH:
  - imem_req=1 while in state.
  - On imem_ack=1: ir_load=1 in that same cycle (combinational from ack), then -> DECODE.
  - With no ack, wait indefinitely with imem_req held high.
- DECODE (1 cycle):
  - opcode is in the reserved set (01010..01111, 10110..11111) -> FAULT. No writes, no PC change, retired_cnt unchanged.
  - Else -> EXECUTE.
- EXECUTE (1 cycle): register reads and ALU settle; no strobes.
- WRITEBACK (1 cycle):
  - reg_wr_en=dec_wr_en; stat_wr_en=dec_stat_wr_en.
  - pc_wr_en=dec_cnt_wr_en; pc_inc=~dec_cnt_wr_en. The two are never both 1.
  - retired_cnt += 1, saturating at all-ones.
  - Next state:
    - halt_req=1 or step_pending=1 or run=0 -> IDLE (clear step_pending).
    - Else -> FETCH.
- Instruction latency: 4 cycles with a zero-wait-state memory (ack in first FETCH cycle), i.e. FETCH, DECODE, EXECUTE, WRITEBACK.
- halt_req asserted mid-instruction never aborts it. The current instruction completes WRITEBACK, then the FSM enters IDLE.
- FAULT:
  - fault=1, halted=1, busy=0, all strobes 0.
  - run and step are ignored.
  - fault_clr=1 -> IDLE.
- step during busy is ignored (not queued).
- Reset mid-instruction: immediate return to IDLE. No strobe may be asserted in the cycle after rst_n deasserts.
- NOP and VAL need no special handling; the strobes follow the decoder.

Test Plan:
- Reset, then run=1, memory acks in first FETCH cycle, program ADD,NOP -> imem_req at cycles 0 and 4; reg_wr_en=1 at cycle 3 only; pc_inc at cycles 3 and 7; retired_cnt=2 after cycle 7.
- step pulse with run=0, GOTO (dec_cnt_wr_en=1) -> exactly one pc_wr_en pulse, pc_inc=0 throughout; FSM back in IDLE; halted=1; retired_cnt=1.
- run=1, imem_ack delayed 3 cycles -> imem_req held 4 cycles; ir_load exactly one cycle, coincident with ack; no other strobes during wait.
- Opcode 5'b01011 fetched -> FAULT after DECODE; no reg/stat/PC strobes; retired_cnt unchanged; run ignored; fault_clr -> IDLE, fault=0.
- halt_req pulsed during EXECUTE of an instruction with run=1 -> WRITEBACK completes with its strobes, then IDLE; no further imem_req.
- rst_n pulled low during WRITEBACK of ADD -> all strobes drop asynchronously; retired_cnt=0; halted=1.
